mul_div_unit: RTL and testbench
===============================

# mul_div_unit

Iterative 32-bit multiply/divide unit for the MIPS datapath, covering MULT, MULTU, DIV, DIVU, MTHI and MTLO. It sits beside the combinational ALU on the same rs/rt operand buses. It owns the architectural HI/LO registers and reports completion through a start/busy/done handshake, so the pipeline controller can stall MFHI/MFLO until the result is ready. Operations use radix-2 shift-add multiply and restoring division.

## Interface
- Parameters: none (datapath fixed at 32 bits, iteration count fixed at 32).
- clk  in  1  sole clock, rising-edge.
- reset  in  1  synchronous, active-high.
- start  in  1  request; sampled only in IDLE.
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start.
- in1  in  32  rs operand (multiplicand / dividend).
- in2  in  32  rt operand (multiplier / divisor).
- hi_we  in  1  MTHI write strobe.
- lo_we  in  1  MTLO write strobe.
- wdata  in  32  MTHI/MTLO data.
- busy  out  1  high while an operation is in flight.
- done  out  1  one-cycle pulse when HI/LO take a new result.
- div_by_zero  out  1  valid with done; 1 if the completed DIV/DIVU had in2 == 0.
- hi  out  32  HI register.
- lo  out  32  LO register.

## Operation
- **Reset values:** all outputs 0 (hi, lo, busy, done, div_by_zero); state IDLE; iteration counter 0.
- **States:**
  - IDLE -> RUN on start.
  - RUN -> RUN for 32 iterations, then -> FIX.
  - FIX -> IDLE unconditionally.
- **Accept (IDLE, start=1):**
  - Latch op and the sign flags.
  - Latch |in1| and |in2|; magnitudes are taken only for MULT/DIV, and unsigned ops latch operands raw.
  - Clear the 64-bit accumulator and the counter.
- **RUN, multiply:** per cycle, if multiplier LSB is 1, add multiplicand to the accumulator's upper 33 bits; then shift the accumulator and the multiplier right by 1.
- **RUN, divide:** per cycle, shift {rem, quot} left by 1; trial-subtract the divisor from rem; if the result is non-negative, keep it and set quot LSB.
- **FIX, signed result correction:**
  - MULT: negate the 64-bit product if the operand signs differ.
  - DIV: negate the quotient if the signs differ; negate the remainder if in1 was negative.
- **FIX, register write:**
  - Multiply: {hi, lo} = product.
  - Divide: lo = quotient (truncated toward zero), hi = remainder (sign follows dividend).
- **Divide by zero:** hi = original in1, lo = 32'hFFFFFFFF, div_by_zero = 1. Applies to both DIV and DIVU. div_by_zero is 0 for every other completion.
- **Overflow:** DIV 0x80000000 / 0xFFFFFFFF gives lo = 0x80000000, hi = 0; no flag.
- **MTHI/MTLO:**
  - hi_we/lo_we write wdata at the next edge in any state.
  - If a FIX completion coincides with a write on the same edge, the completion wins.
  - A write during RUN is therefore overwritten when the operation finishes.
- **Start while busy:** ignored; no queueing.
- **Reset mid-operation:** aborts the operation; IDLE, hi/lo = 0, no done pulse.

## Timing
- Edge E0: start accepted. busy = (state != IDLE), so it is high from the cycle after E0.
- Edges E1..E32: the 32 iterations.
- Edge E33: FIX writes hi/lo, registers done = 1, returns to IDLE.
- Cycle after E33: done high for exactly one cycle; busy low; new hi/lo visible.
- Total latency: start edge to result visible = 33 cycles, identical for all four ops including divide-by-zero.
- Throughput: a new start is accepted in the same cycle done is high (back-to-back), giving one op per 34 cycles.
- div_by_zero is registered with done and cleared on the next accepted start.
- hi/lo are never modified during RUN; intermediate state lives in internal registers.

## Test plan
- **MULTU:** in1 = in2 = 0xFFFFFFFF -> hi = 0xFFFFFFFE, lo = 0x00000001. done exactly 33 cycles after the start edge; busy high for 33 cycles.
- **MULT:** 0xFFFFFFFD (-3) × 0x00000007 -> hi = 0xFFFFFFFF, lo = 0xFFFFFFEB. Back-to-back: MULTU 0x00010000 × 0x00010000 started in the done cycle -> hi = 0x00000001, lo = 0.
- **DIV / DIVU:**
  - DIV 0xFFFFFFF9 (-7) / 2 -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
  - DIVU 0xFFFFFFF9 / 2 -> lo = 0x7FFFFFFC, hi = 0x00000001.
- **Corner cases:**
  - DIV 0x80000000 / 0xFFFFFFFF -> lo = 0x80000000, hi = 0, div_by_zero = 0.
  - DIV 5 / 0 -> hi = 5, lo = 0xFFFFFFFF, div_by_zero = 1 with done.
- **Handshake:**
  - Second start with different operands at cycle 10 of RUN -> ignored; first result returned.
  - lo_we with wdata 0x12345678 in IDLE -> lo = 0x12345678 next cycle.
  - lo_we at cycle 5 of RUN -> lo shows 0x12345678 until E33, then the op result.
- **Reset:** reset at cycle 20 of a DIV -> busy, done, hi, lo = 0 next cycle. No done pulse ever follows; a fresh start then completes normally.

Source files
------------

// File: rtl/mul_div_unit.sv
// Iterative 32-bit multiply/divide unit owning HI/LO.
// Radix-2 shift-add multiply and restoring divide, 33-cycle latency.
module mul_div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic        is_div;
  logic        neg_a;
  logic        neg_b;
  logic        dz;
  logic [31:0] opa;
  logic [31:0] opb;
  logic [63:0] acc;

  logic        sa;
  logic        sb;
  logic [31:0] mag1;
  logic [31:0] mag2;
  logic [32:0] msum;
  logic [63:0] mul_next;
  logic [32:0] rsh;
  logic [32:0] trial;
  logic        qbit;
  logic [63:0] div_next;
  logic [63:0] prod;
  logic [31:0] quot;
  logic [31:0] rem;

  assign busy = (state != IDLE);

  always_comb begin
    sa   = ~op[0] & in1[31];
    sb   = ~op[0] & in2[31];
    mag1 = sa ? (~in1 + 32'd1) : in1;
    mag2 = sb ? (~in2 + 32'd1) : in2;
    msum = {1'b0, acc[63:32]}
         + (opb[0] ? {1'b0, opa} : 33'd0);
    mul_next = {msum, acc[31:1]};
    // dividend bits stream in from opa's MSB
    rsh   = {acc[63:32], opa[31]};
    trial = rsh - {1'b0, opb};
    qbit  = ~trial[32];
    div_next = {qbit ? trial[31:0] : rsh[31:0],
                acc[30:0], qbit};
    prod = (neg_a ^ neg_b) ? (~acc + 64'd1) : acc;
    quot = (neg_a ^ neg_b) ? (~acc[31:0] + 32'd1)
                           : acc[31:0];
    rem  = neg_a ? (~acc[63:32] + 32'd1)
                 : acc[63:32];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= 5'd0;
      is_div      <= 1'b0;
      neg_a       <= 1'b0;
      neg_b       <= 1'b0;
      dz          <= 1'b0;
      opa         <= 32'd0;
      opb         <= 32'd0;
      acc         <= 64'd0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= 32'd0;
      lo          <= 32'd0;
    end else begin
      done <= 1'b0;
      if (hi_we) hi <= wdata;
      if (lo_we) lo <= wdata;
      unique case (state)
        IDLE: begin
          if (start) begin
            state       <= RUN;
            cnt         <= 5'd0;
            is_div      <= op[1];
            neg_a       <= sa;
            neg_b       <= sb;
            opa         <= mag1;
            opb         <= mag2;
            acc         <= 64'd0;
            dz          <= op[1] & (in2 == 32'd0);
            div_by_zero <= 1'b0;
          end
        end
        RUN: begin
          cnt <= cnt + 5'd1;
          if (is_div) begin
            acc <= div_next;
            opa <= {opa[30:0], 1'b0};
          end else begin
            acc <= mul_next;
            opb <= {1'b0, opb[31:1]};
          end
          if (cnt == 5'd31) state <= FIX;
        end
        FIX: begin
          state       <= IDLE;
          done        <= 1'b1;
          div_by_zero <= dz;
          // completion overrides a same-edge MTHI/MTLO
          if (is_div) begin
            hi <= rem;
            lo <= dz ? 32'hFFFF_FFFF : quot;
          end else begin
            hi <= prod[63:32];
            lo <= prod[31:0];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Randomised and directed bench for mul_div_unit.
// Cycle-level reference model compared on every negedge.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] in1 = 32'd0;
  logic [31:0] in2 = 32'd0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic [31:0] wdata = 32'd0;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  mul_div_unit dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .op(op),
    .in1(in1),
    .in2(in2),
    .hi_we(hi_we),
    .lo_we(lo_we),
    .wdata(wdata),
    .busy(busy),
    .done(done),
    .div_by_zero(div_by_zero),
    .hi(hi),
    .lo(lo)
  );

  task automatic check(input string name,
                       input logic [95:0] act,
                       input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  // {div_by_zero, hi, lo} from plain arithmetic
  function automatic logic [64:0] ref_fn(
    input logic [1:0] o,
    input logic [31:0] a,
    input logic [31:0] b);
    longint p;
    longint unsigned pu;
    int q;
    int r;
    case (o)
      2'd0: begin
        p = longint'($signed(a)) * longint'($signed(b));
        return {1'b0, p};
      end
      2'd1: begin
        pu = {32'd0, a} * {32'd0, b};
        return {1'b0, pu};
      end
      2'd2: begin
        if (b == 32'd0)
          return {1'b1, a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
          return {1'b0, 32'd0, 32'h8000_0000};
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        return {1'b0, r, q};
      end
      default: begin
        if (b == 32'd0)
          return {1'b1, a, 32'hFFFF_FFFF};
        return {1'b0, a % b, a / b};
      end
    endcase
  endfunction

  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  logic        m_done = 1'b0;
  logic        m_dz = 1'b0;
  int          m_left = 0;
  logic [64:0] m_pend = 65'd0;

  // m_left counts edges until the result lands
  always @(posedge clk) begin
    if (reset) begin
      m_hi <= 32'd0;
      m_lo <= 32'd0;
      m_done <= 1'b0;
      m_dz <= 1'b0;
      m_left <= 0;
    end else begin
      m_done <= 1'b0;
      if (hi_we) m_hi <= wdata;
      if (lo_we) m_lo <= wdata;
      if (m_left == 0) begin
        if (start) begin
          m_pend <= ref_fn(op, in1, in2);
          m_left <= 33;
          m_dz <= 1'b0;
        end
      end else begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_hi <= m_pend[63:32];
          m_lo <= m_pend[31:0];
          m_dz <= m_pend[64];
          m_done <= 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en)
      check("cycle",
            96'({busy, done, div_by_zero, hi, lo}),
            96'({m_left != 0, m_done, m_dz, m_hi, m_lo}));
  end

  task automatic do_op(input logic [1:0] o,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input bit rnd,
                       output int bcnt);
    int lat;
    op = o;
    in1 = a;
    in2 = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    bcnt = busy ? 1 : 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      hi_we = 1'b0;
      lo_we = 1'b0;
      lat++;
      if (busy) bcnt++;
      if (rnd && !done && $urandom_range(7) == 0) begin
        wdata = $urandom;
        hi_we = 1'($urandom_range(1));
        lo_we = 1'($urandom_range(1));
      end
    end
    check("latency", 96'(lat), 96'd33);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", 96'(done), 96'd1);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int bc;
    int npulse;
    repeat (2) @(negedge clk);
    check("reset_state",
          96'({busy, done, div_by_zero, hi, lo}), 96'd0);
    reset = 1'b0;
    chk_en = 1'b1;

    check("ref_multu",
          96'(ref_fn(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF)),
          96'({1'b0, 32'hFFFF_FFFE, 32'h0000_0001}));
    check("ref_mult",
          96'(ref_fn(2'd0, 32'hFFFF_FFFD, 32'd7)),
          96'({1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFEB}));
    check("ref_div",
          96'(ref_fn(2'd2, 32'hFFFF_FFF9, 32'd2)),
          96'({1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD}));
    check("ref_divu",
          96'(ref_fn(2'd3, 32'hFFFF_FFF9, 32'd2)),
          96'({1'b0, 32'h0000_0001, 32'h7FFF_FFFC}));
    check("ref_dz",
          96'(ref_fn(2'd2, 32'd5, 32'd0)),
          96'({1'b1, 32'd5, 32'hFFFF_FFFF}));

    @(negedge clk);
    lo_we = 1'b1;
    wdata = 32'h1234_5678;
    @(negedge clk);
    lo_we = 1'b0;
    check("mtlo_idle", 96'(lo), 96'h1234_5678);

    do_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, bc);
    check("busy_cycles", 96'(bc), 96'd33);
    check("multu", 96'({hi, lo}),
          96'({32'hFFFF_FFFE, 32'h0000_0001}));

    do_op(2'd0, 32'hFFFF_FFFD, 32'd7, 1'b0, bc);
    check("mult", 96'({hi, lo}),
          96'({32'hFFFF_FFFF, 32'hFFFF_FFEB}));
    do_op(2'd1, 32'h0001_0000, 32'h0001_0000, 1'b0, bc);
    check("b2b_multu", 96'({hi, lo}),
          96'({32'd1, 32'd0}));

    do_op(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, bc);
    check("div", 96'({hi, lo}),
          96'({32'hFFFF_FFFF, 32'hFFFF_FFFD}));
    do_op(2'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, bc);
    check("divu", 96'({hi, lo}),
          96'({32'd1, 32'h7FFF_FFFC}));
    do_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, bc);
    check("div_ovf", 96'({div_by_zero, hi, lo}),
          96'({1'b0, 32'd0, 32'h8000_0000}));
    do_op(2'd2, 32'd5, 32'd0, 1'b0, bc);
    check("div_zero", 96'({done, div_by_zero, hi, lo}),
          96'({1'b1, 1'b1, 32'd5, 32'hFFFF_FFFF}));

    op = 2'd3;
    in1 = 32'd100;
    in2 = 32'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    op = 2'd1;
    in1 = 32'd5;
    in2 = 32'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    check("ignored_start", 96'({hi, lo}),
          96'({32'd2, 32'd14}));

    op = 2'd3;
    in1 = 32'd1000;
    in2 = 32'd10;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    lo_we = 1'b1;
    wdata = 32'h1234_5678;
    @(negedge clk);
    lo_we = 1'b0;
    @(negedge clk);
    check("mtlo_run", 96'(lo), 96'h1234_5678);
    wait_done();
    check("mtlo_overwritten", 96'({hi, lo}),
          96'({32'd0, 32'd100}));

    op = 2'd2;
    in1 = 32'h7FFF_FFFF;
    in2 = 32'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("reset_abort",
          96'({busy, done, hi, lo}), 96'd0);
    npulse = 0;
    repeat (45) begin
      @(negedge clk);
      if (done) npulse++;
    end
    check("no_done_after_reset", 96'(npulse), 96'd0);
    do_op(2'd2, 32'd100, 32'hFFFF_FFF9, 1'b0, bc);
    check("after_reset_div", 96'({hi, lo}),
          96'({32'd2, 32'hFFFF_FFF2}));

    for (int i = 0; i < 60; i++) begin
      do_op(2'($urandom_range(3)), pick(), pick(),
            1'b1, bc);
      repeat ($urandom_range(2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
